instr_fetch_queue: RTL and testbench

Upstream feeder for the 8-bit compute unit. Assembles 16-bit instructions from a byte-serial input: high byte (opcode, target register) first, then low byte (source registers or load immediate). Buffers completed instructions in a small first-word-fall-through FIFO. Issues them to the compute unit over a valid/ready handshake, so instructions can be streamed in faster than they are consumed without loss.

---
 rtl/instr_fetch_queue.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Byte-serial instruction assembler feeding a first-word-fall-through FIFO.
// Two bytes (high then low) form one 16-bit instruction; the FIFO issues them over valid/ready.
module instr_fetch_queue #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 2,
    parameter bit DROP_NOP = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              flush,
    output logic [15:0]       instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic              asm_busy
);

    localparam logic [ADDR_W:0] LP_DEPTH = ADDR_W'(DEPTH) == '0 ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        S_WAIT_HI = 1'b0,
        S_WAIT_LO = 1'b1
    } asm_state_t;

    asm_state_t          r_state;
    asm_state_t          w_state_nxt;
    logic [7:0]          r_hi_byte;
    logic [15:0]         r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_overflow;

    logic                w_push_req;
    logic                w_capture_hi;
    logic [15:0]         w_instr;
    logic                w_is_nop;
    logic                w_push_try;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic                w_ovf_set;

    // Assembler state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT_HI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Assembler next state; flush forces back to the high-byte wait
    always_comb begin
        w_state_nxt = r_state;
        if (ena) begin
            if (flush) begin
                w_state_nxt = S_WAIT_HI;
            end else begin
                case (r_state)
                    S_WAIT_HI: if (byte_valid) w_state_nxt = S_WAIT_LO;
                    S_WAIT_LO: if (byte_valid) w_state_nxt = S_WAIT_HI;
                    default:   w_state_nxt = S_WAIT_HI;
                endcase
            end
        end
    end

    // Assembler outputs
    always_comb begin
        asm_busy     = 1'b0;
        w_push_req   = 1'b0;
        w_capture_hi = 1'b0;
        case (r_state)
            S_WAIT_HI: w_capture_hi = ena & ~flush & byte_valid;
            S_WAIT_LO: begin
                asm_busy   = 1'b1;
                w_push_req = ena & ~flush & byte_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_byte <= 8'h00;
        end else if (w_capture_hi) begin
            r_hi_byte <= byte_in;
        end
    end

    assign w_instr    = {r_hi_byte, byte_in};
    assign w_is_nop   = (w_instr[15:12] == 4'b0000);
    assign w_push_try = w_push_req & ~(DROP_NOP & w_is_nop);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LP_DEPTH);
    assign w_pop   = ena & ~flush & ~w_empty & instr_ready;

    // A full queue still accepts when the head leaves in the same cycle
    assign w_push    = w_push_try & (~w_full | w_pop);
    assign w_ovf_set = w_push_try & w_full & ~w_pop;

    // Storage carries no reset; the empty mask hides stale entries
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (ena) begin
            if (flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                if (w_ovf_set) r_overflow <= 1'b1;
            end
        end
    end

    assign instr_valid = ~w_empty;
    assign instr_out   = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
    assign count       = r_count;
    assign full        = w_full;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: vector table plus hand sequences, with a queue scoreboard
// predicting every issued instruction and the status outputs each cycle.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        flush;
    logic        instr_ready;

    logic [15:0] instr_out;
    logic        instr_valid;
    logic [2:0]  count;
    logic        full;
    logic        overflow;
    logic        asm_busy;

    logic [15:0] n_instr_out;
    logic        n_instr_valid;
    logic [2:0]  n_count;
    logic        n_full;
    logic        n_overflow;
    logic        n_asm_busy;

    int n_pass = 0;
    int n_tot  = 0;

    logic [15:0] sb_q[$];
    bit          m_busy;
    bit          m_ovf;
    logic [7:0]  m_hi;
    logic [15:0] m_last;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(2), .DROP_NOP(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .byte_in(byte_in), .byte_valid(byte_valid),
        .flush(flush), .instr_out(instr_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .count(count), .full(full), .overflow(overflow),
        .asm_busy(asm_busy)
    );

    instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(2), .DROP_NOP(1'b1)) u_dut_nop (
        .clk(clk), .rst_n(rst_n), .ena(ena), .byte_in(byte_in), .byte_valid(byte_valid),
        .flush(flush), .instr_out(n_instr_out), .instr_valid(n_instr_valid),
        .instr_ready(instr_ready), .count(n_count), .full(n_full), .overflow(n_overflow),
        .asm_busy(n_asm_busy)
    );

    typedef struct {
        logic        bv;
        logic [7:0]  b;
        logic        rdy;
        logic [2:0]  e_count;
        logic        e_valid;
        logic [15:0] e_instr;
        logic        e_busy;
        logic        e_full;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic bv, input logic [7:0] b, input logic rdy,
                                input logic [2:0] c, input logic v, input logic [15:0] ins,
                                input logic bz, input logic fu, input logic ov);
        vec_t r;
        r.bv = bv; r.b = b; r.rdy = rdy; r.e_count = c; r.e_valid = v;
        r.e_instr = ins; r.e_busy = bz; r.e_full = fu; r.e_ovf = ov;
        return r;
    endfunction

    // One clock: drive, predict with the scoreboard, then compare status after the edge
    task automatic cyc(input logic bv, input logic [7:0] b, input logic rdy,
                       input logic fl, input logic en);
        bit pop;
        logic [15:0] w;
        byte_valid = bv; byte_in = b; instr_ready = rdy; flush = fl; ena = en;
        #1;
        pop = en && !fl && rdy && (sb_q.size() > 0);
        if (pop) begin
            chk("sb_pop_data", 32'(instr_out), 32'(sb_q[0]));
            m_last = sb_q[0];
            void'(sb_q.pop_front());
        end
        if (en) begin
            if (fl) begin
                sb_q.delete();
                m_busy = 1'b0;
                m_ovf  = 1'b0;
            end else if (bv) begin
                if (m_busy) begin
                    w = {m_hi, b};
                    if (sb_q.size() < DEPTH) sb_q.push_back(w);
                    else m_ovf = 1'b1;
                    m_busy = 1'b0;
                end else begin
                    m_hi   = b;
                    m_busy = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("sb_count", 32'(count), 32'(sb_q.size()));
        chk("sb_valid", 32'(instr_valid), 32'(sb_q.size() > 0));
        chk("sb_head", 32'(instr_out), (sb_q.size() > 0) ? 32'(sb_q[0]) : 32'h0);
        chk("sb_full", 32'(full), 32'(sb_q.size() == DEPTH));
        chk("sb_ovf", 32'(overflow), 32'(m_ovf));
        chk("sb_busy", 32'(asm_busy), 32'(m_busy));
    endtask

    task automatic send(input logic [15:0] ins, input logic rdy);
        cyc(1'b1, ins[15:8], rdy, 1'b0, 1'b1);
        cyc(1'b1, ins[7:0], rdy, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", 32'(instr_out), 32'h0);
        chk("rst_busy", 32'(asm_busy), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        sb_q.delete();
        m_busy = 1'b0;
        m_ovf  = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        flush = 1'b0; instr_ready = 1'b0; m_hi = 8'h00; m_last = 16'h0;
        m_busy = 1'b0; m_ovf = 1'b0;

        // Single instruction latency, fill/overflow and drain
        tbl.push_back(mk(1, 8'h91, 0, 3'd0, 0, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(1, 8'h2A, 0, 3'd1, 1, 16'h912A, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 3'd0, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 8'h91, 0, 3'd0, 0, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(1, 8'h05, 0, 3'd1, 1, 16'h9105, 0, 0, 0));
        tbl.push_back(mk(1, 8'h92, 0, 3'd1, 1, 16'h9105, 1, 0, 0));
        tbl.push_back(mk(1, 8'h03, 0, 3'd2, 1, 16'h9105, 0, 0, 0));
        tbl.push_back(mk(1, 8'hA3, 0, 3'd2, 1, 16'h9105, 1, 0, 0));
        tbl.push_back(mk(1, 8'h12, 0, 3'd3, 1, 16'h9105, 0, 0, 0));
        tbl.push_back(mk(1, 8'hF1, 0, 3'd3, 1, 16'h9105, 1, 0, 0));
        tbl.push_back(mk(1, 8'h23, 0, 3'd4, 1, 16'h9105, 0, 1, 0));
        tbl.push_back(mk(1, 8'hB0, 0, 3'd4, 1, 16'h9105, 1, 1, 0));
        tbl.push_back(mk(1, 8'h00, 0, 3'd4, 1, 16'h9105, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 3'd3, 1, 16'h9203, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 3'd2, 1, 16'hA312, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 3'd1, 1, 16'hF123, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 3'd0, 0, 16'h0000, 0, 0, 1));

        #3;
        do_reset();

        foreach (tbl[i]) begin
            cyc(tbl[i].bv, tbl[i].b, tbl[i].rdy, 1'b0, 1'b1);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_instr", i), 32'(instr_out), 32'(tbl[i].e_instr));
            chk($sformatf("v%0d_busy", i), 32'(asm_busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].e_full));
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
        end
        chk("drain_last", 32'(m_last), 32'h0000F123);

        // Full queue with a simultaneous push and pop
        cyc(0, 8'h00, 0, 1'b1, 1'b1);
        send(16'h1111, 0);
        send(16'h2222, 0);
        send(16'h3333, 0);
        send(16'h4444, 0);
        cyc(1, 8'hC4, 0, 1'b0, 1'b1);
        cyc(1, 8'h56, 1, 1'b0, 1'b1);
        chk("t3_count", 32'(count), 32'd4);
        chk("t3_ovf", 32'(overflow), 32'd0);
        chk("t3_head", 32'(instr_out), 32'h2222);
        for (int k = 0; k < 4; k++) cyc(0, 8'h00, 1, 1'b0, 1'b1);
        chk("t3_last", 32'(m_last), 32'h0000C456);
        chk("t3_empty", 32'(instr_valid), 32'd0);

        // Long gap between bytes, then reset between bytes
        cyc(1, 8'h91, 0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 8'h00, 0, 1'b0, 1'b1);
            chk("t4_busy_hold", 32'(asm_busy), 32'd1);
        end
        cyc(1, 8'h07, 0, 1'b0, 1'b1);
        chk("t4_instr", 32'(instr_out), 32'h9107);
        cyc(0, 8'h00, 1, 1'b0, 1'b1);
        cyc(1, 8'h91, 0, 1'b0, 1'b1);
        do_reset();
        cyc(0, 8'h00, 0, 1'b0, 1'b1);
        chk("t4_post_rst_busy", 32'(asm_busy), 32'd0);
        chk("t4_post_rst_count", 32'(count), 32'd0);

        // NOP dropping on the DROP_NOP instance
        send(16'h0055, 0);
        send(16'h9A01, 0);
        chk("t5_nop_count", 32'(n_count), 32'd1);
        chk("t5_nop_head", 32'(n_instr_out), 32'h9A01);
        chk("t5_nop_valid", 32'(n_instr_valid), 32'd1);
        chk("t5_keep_count", 32'(count), 32'd2);
        chk("t5_keep_head", 32'(instr_out), 32'h0055);

        // Flush against a pending low byte and pop, then ena low holds state
        send(16'h5A5A, 0);
        send(16'h6B6B, 0);
        send(16'h7C7C, 0);
        chk("t6_ovf_set", 32'(overflow), 32'd1);
        cyc(0, 8'h00, 1, 1'b0, 1'b1);
        chk("t6_three", 32'(count), 32'd3);
        cyc(1, 8'hC1, 0, 1'b0, 1'b1);
        cyc(1, 8'h22, 1, 1'b1, 1'b1);
        chk("t6_fl_count", 32'(count), 32'd0);
        chk("t6_fl_ovf", 32'(overflow), 32'd0);
        chk("t6_fl_busy", 32'(asm_busy), 32'd0);
        chk("t6_fl_valid", 32'(instr_valid), 32'd0);
        send(16'h9311, 0);
        cyc(1, 8'h9F, 0, 1'b0, 1'b1);
        cyc(1, 8'h55, 1, 1'b0, 1'b0);
        cyc(1, 8'h66, 1, 1'b1, 1'b0);
        chk("t6_ena_count", 32'(count), 32'd1);
        chk("t6_ena_busy", 32'(asm_busy), 32'd1);
        chk("t6_ena_head", 32'(instr_out), 32'h9311);
        cyc(1, 8'h01, 0, 1'b0, 1'b1);
        chk("t6_resume", 32'(count), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
